// File: rtl/cp0_pkg.sv
//------------------------------------------------------------------------------
// cp0_pkg : shared CP0 register numbers, ExcCodes, bit positions, write masks
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_TI     = 30;
    localparam int CAUSE_BD     = 31;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    // Only address-error exceptions carry a meaningful bad virtual address.
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_regfile_if.sv
//------------------------------------------------------------------------------
// cp0_regfile_if : pipeline <-> CP0 bundle (mtc0/mfc0, exceptions, status out)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface cp0_regfile_if;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic [5:0]  hw_int;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        int_req;

    modport master (
        output cp0_we, cp0_waddr, cp0_wdata, cp0_raddr, hw_int,
               exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr, eret,
        input  cp0_rdata, status_o, cause_o, epc_o, int_req
    );

    modport slave (
        input  cp0_we, cp0_waddr, cp0_wdata, cp0_raddr, hw_int,
               exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr, eret,
        output cp0_rdata, status_o, cause_o, epc_o, int_req
    );
endinterface

`default_nettype wire

// File: rtl/cp0_timer.sv
//------------------------------------------------------------------------------
// cp0_timer : clock divider, Count/Compare registers and timer interrupt (TI)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cp0_timer #(
    parameter int unsigned COUNT_DIV = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        count_we,
    input  wire logic        compare_we,
    input  wire logic [31:0] wdata,
    output logic      [31:0] count,
    output logic      [31:0] compare,
    output logic             ti
);

    logic        w_tick;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ti;

    generate
        if (COUNT_DIV == 0) begin : g_div_none
            assign w_tick = 1'b1;
        end else begin : g_div_on
            logic [COUNT_DIV-1:0] r_div;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_div <= '0;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end

            assign w_tick = &r_div;
        end
    endgenerate

    // Match is judged on the Count value held before this cycle's update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count   <= '0;
            r_compare <= '0;
            r_ti      <= 1'b0;
        end else begin
            if (count_we) begin
                r_count <= wdata;
            end else if (w_tick) begin
                r_count <= r_count + 32'd1;
            end

            if (compare_we) begin
                r_compare <= wdata;
            end

            if (compare_we) begin
                r_ti <= 1'b0;
            end else if (w_tick && (r_count == r_compare)) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign count   = r_count;
    assign compare = r_compare;
    assign ti      = r_ti;

endmodule

`default_nettype wire

// File: rtl/cp0_regfile.sv
//------------------------------------------------------------------------------
// cp0_regfile : MIPS32 CP0 registers, exception/ERET tracking, interrupt request
// Optional macro CP0_TIMER_EN adds the Count/Compare timer.  Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cp0_regfile
    import cp0_pkg::*;
#(
    parameter int unsigned COUNT_DIV  = 1,
    parameter logic [31:0] STATUS_RST = 32'h1040_0000
) (
    input  wire logic  clk,
    input  wire logic  rst,
    cp0_regfile_if.slave bus
);

    logic [31:0] r_status;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic        r_bd;
    logic [4:0]  r_exccode;
    logic [1:0]  r_ip_sw;
    logic [5:0]  r_hw;
    logic        r_int_req;

    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_ti;
    logic [31:0] w_cause;
    logic [31:0] w_rdata;

    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;
    logic        w_wr_count;
    logic        w_wr_compare;

    assign w_wr_status  = bus.cp0_we && (bus.cp0_waddr == CP0_STATUS);
    assign w_wr_cause   = bus.cp0_we && (bus.cp0_waddr == CP0_CAUSE);
    assign w_wr_epc     = bus.cp0_we && (bus.cp0_waddr == CP0_EPC);
    assign w_wr_count   = bus.cp0_we && (bus.cp0_waddr == CP0_COUNT);
    assign w_wr_compare = bus.cp0_we && (bus.cp0_waddr == CP0_COMPARE);

`ifdef CP0_TIMER_EN
    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (w_wr_count),
        .compare_we (w_wr_compare),
        .wdata      (bus.cp0_wdata),
        .count      (w_count),
        .compare    (w_compare),
        .ti         (w_ti)
    );
`else
    // COUNT_DIV has no effect without the timer; all timer state reads zero.
    assign w_count   = 32'(COUNT_DIV) & 32'h0;
    assign w_compare = '0;
    assign w_ti      = 1'b0;
`endif

    // Field priority: exception over ERET over mtc0 (later NBAs win).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_status <= STATUS_RST;
        end else begin
            if (w_wr_status) begin
                r_status <= (r_status & ~STATUS_WMASK) | (bus.cp0_wdata & STATUS_WMASK);
            end
            if (bus.eret) begin
                r_status[STATUS_EXL] <= 1'b0;
            end
            if (bus.exc_valid) begin
                r_status[STATUS_EXL] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_epc      <= '0;
            r_bd       <= 1'b0;
            r_exccode  <= '0;
            r_badvaddr <= '0;
        end else begin
            if (bus.exc_valid) begin
                // A nested exception keeps the EPC/BD of the outer one.
                if (!r_status[STATUS_EXL]) begin
                    r_epc <= bus.exc_bd ? (bus.exc_pc - 32'd4) : bus.exc_pc;
                    r_bd  <= bus.exc_bd;
                end
                r_exccode <= bus.exc_code;
                if (is_addr_exc(bus.exc_code)) begin
                    r_badvaddr <= bus.exc_badvaddr;
                end
            end else if (w_wr_epc) begin
                r_epc <= bus.cp0_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ip_sw <= '0;
            r_hw    <= '0;
        end else begin
            r_hw <= bus.hw_int;
            if (w_wr_cause) begin
                r_ip_sw <= bus.cp0_wdata[9:8];
            end
        end
    end

    assign w_cause = {r_bd, w_ti, 14'b0, r_hw[5] | w_ti, r_hw[4:0],
                      r_ip_sw, 1'b0, r_exccode, 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_int_req <= 1'b0;
        end else begin
            r_int_req <= r_status[STATUS_IE] & ~r_status[STATUS_EXL]
                         & (|(w_cause[15:8] & r_status[15:8]));
        end
    end

    always_comb begin
        w_rdata = '0;
        case (bus.cp0_raddr)
            CP0_BADVADDR: w_rdata = r_badvaddr;
            CP0_COUNT:    w_rdata = w_count;
            CP0_COMPARE:  w_rdata = w_compare;
            CP0_STATUS:   w_rdata = r_status;
            CP0_CAUSE:    w_rdata = w_cause;
            CP0_EPC:      w_rdata = r_epc;
            default:      w_rdata = '0;
        endcase
    end

    assign bus.cp0_rdata = w_rdata;
    assign bus.status_o  = r_status;
    assign bus.cause_o   = w_cause;
    assign bus.epc_o     = r_epc;
    assign bus.int_req   = r_int_req;

endmodule

`default_nettype wire

// File: tb/tb_cp0_regfile.sv
//------------------------------------------------------------------------------
// tb_cp0_regfile : scoreboard bench for cp0_regfile (default and CP0_TIMER_EN)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cp0_regfile;

    localparam int SRC_STATUS = 32;
    localparam int SRC_CAUSE  = 33;
    localparam int SRC_EPC    = 34;
    localparam int SRC_INTREQ = 35;

    typedef struct {
        string       tag;
        int          src;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    exp_t sb_q[$];

    cp0_regfile_if bus ();

    cp0_regfile #(
        .COUNT_DIV  (1),
        .STATUS_RST (32'h1040_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int src, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.src = src;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.src < 32) bus.cp0_raddr = e.src[4:0];
            #1;
            case (e.src)
                SRC_STATUS: chk(e.tag, bus.status_o, e.exp);
                SRC_CAUSE:  chk(e.tag, bus.cause_o, e.exp);
                SRC_EPC:    chk(e.tag, bus.epc_o, e.exp);
                SRC_INTREQ: chk(e.tag, {31'b0, bus.int_req}, e.exp);
                default:    chk(e.tag, bus.cp0_rdata, e.exp);
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.cp0_we    = 1'b1;
        bus.cp0_waddr = a;
        bus.cp0_wdata = d;
        tick();
        bus.cp0_we    = 1'b0;
    endtask

    task automatic raise_exc(input logic [4:0] code, input logic [31:0] pc,
                             input logic bd, input logic [31:0] bva);
        bus.exc_valid    = 1'b1;
        bus.exc_code     = code;
        bus.exc_pc       = pc;
        bus.exc_bd       = bd;
        bus.exc_badvaddr = bva;
        tick();
        bus.exc_valid    = 1'b0;
    endtask

    initial begin
        n_assert         = 0;
        n_fail           = 0;
        rst              = 1'b0;
        bus.cp0_we       = 1'b0;
        bus.cp0_waddr    = '0;
        bus.cp0_wdata    = '0;
        bus.cp0_raddr    = '0;
        bus.hw_int       = '0;
        bus.exc_valid    = 1'b0;
        bus.exc_code     = '0;
        bus.exc_pc       = '0;
        bus.exc_bd       = 1'b0;
        bus.exc_badvaddr = '0;
        bus.eret         = 1'b0;

        idle(3);
        expect_val("rst_badvaddr", 8,  32'h0);
        expect_val("rst_count",    9,  32'h0);
        expect_val("rst_unmapped", 10, 32'h0);
        expect_val("rst_compare",  11, 32'h0);
        expect_val("rst_status",   12, 32'h1040_0000);
        expect_val("rst_cause",    13, 32'h0);
        expect_val("rst_epc",      14, 32'h0);
        expect_val("rst_int_req",  SRC_INTREQ, 32'h0);
        drain();

        rst = 1'b1;
        tick();

        mtc0(5'd12, 32'hFFFF_FFFF);
        expect_val("status_wmask", 12, 32'h1040_FF03);
        drain();

        mtc0(5'd3, 32'h0000_ABCD);
        expect_val("unmapped_wr", 3, 32'h0);
        drain();

`ifdef CP0_TIMER_EN
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        idle(3);
        expect_val("timer_early", 13, 32'h0);
        drain();
        idle(13);
        expect_val("timer_ti_ip7", 13, 32'h4000_8000);
        drain();
        mtc0(5'd11, 32'd20);
        expect_val("ti_clear", SRC_CAUSE, 32'h0);
        drain();
        mtc0(5'd11, 32'hFFFF_FFFF);
        mtc0(5'd9, 32'h0000_0100);
        expect_val("count_wr", 9, 32'h0000_0100);
        expect_val("compare_wr", 11, 32'hFFFF_FFFF);
        drain();
`else
        mtc0(5'd9, 32'd7);
        mtc0(5'd11, 32'd3);
        idle(4);
        expect_val("count_off",   9,  32'h0);
        expect_val("compare_off", 11, 32'h0);
        expect_val("ti_off",      13, 32'h0);
        drain();
`endif

        bus.hw_int = 6'b000001;
        tick();
        mtc0(5'd12, 32'h0000_0401);
        expect_val("status_ie_im2", SRC_STATUS, 32'h1040_0401);
        drain();
        tick();
        expect_val("int_req_set", SRC_INTREQ, 32'h1);
        drain();

        mtc0(5'd13, 32'hFFFF_FFFF);
        expect_val("cause_wmask", 13, 32'h0000_0700);
        drain();
        mtc0(5'd13, 32'h0);

        raise_exc(5'd12, 32'h8000_0010, 1'b1, 32'h1111_2222);
        expect_val("exc_epc",      SRC_EPC, 32'h8000_000C);
        expect_val("exc_cause",    13, 32'h8000_0430);
        expect_val("exc_status",   12, 32'h1040_0403);
        expect_val("exc_badva_ov", 8,  32'h0);
        expect_val("exc_irq_lag",  SRC_INTREQ, 32'h1);
        drain();
        tick();
        expect_val("exc_irq_drop", SRC_INTREQ, 32'h0);
        drain();

        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        expect_val("eret_exl", 12, 32'h1040_0401);
        drain();

        bus.cp0_we    = 1'b1;
        bus.cp0_waddr = 5'd14;
        bus.cp0_wdata = 32'h0000_1234;
        raise_exc(5'd8, 32'h8000_0100, 1'b0, 32'h0);
        bus.cp0_we    = 1'b0;
        expect_val("collide_epc",   14, 32'h8000_0100);
        expect_val("collide_cause", 13, 32'h0000_0420);
        drain();

        raise_exc(5'd4, 32'h8000_0200, 1'b1, 32'hDEAD_BEE0);
        expect_val("nested_epc",   14, 32'h8000_0100);
        expect_val("nested_cause", 13, 32'h0000_0410);
        expect_val("nested_badva", 8,  32'hDEAD_BEE0);
        drain();

        bus.eret      = 1'b1;
        bus.cp0_we    = 1'b1;
        bus.cp0_waddr = 5'd12;
        bus.cp0_wdata = 32'h0000_0403;
        tick();
        bus.eret      = 1'b0;
        bus.cp0_we    = 1'b0;
        expect_val("eret_vs_mtc0", 12, 32'h1040_0401);
        drain();

        rst = 1'b0;
        #2;
        expect_val("midrst_status", SRC_STATUS, 32'h1040_0000);
        expect_val("midrst_epc",    SRC_EPC,    32'h0);
        expect_val("midrst_cause",  SRC_CAUSE,  32'h0);
        expect_val("midrst_badva",  8,          32'h0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
